multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be OPC_W (4, opcode width) and ALUOP_W (4, ALU operation code width).
REQ-002 Ports SHALL be: clk  in  1  sole clock; reset  in  1  asynchronous, active-low reset.
REQ-003 Ports SHALL be: opcode  in  OPC_W  instruction[15:12] from IR; zero  in  1  ALU Zero flag; mem_ready  in  1  memory transfer complete.
REQ-004 Ports SHALL be: pc_write  out  1  PC load enable (unconditional or taken branch); i_or_d  out  1  address select (0=PC, 1=ALUOut).
REQ-005 Ports SHALL be: mem_read, mem_write, ir_write, reg_write  out  1 each  strobes; mem_to_reg  out  1  writeback select (0=ALUOut, 1=MDR).
REQ-006 Ports SHALL be: alu_src_a  out  2  (0=PC, 1=const 2, 2=A reg, 3=imm); alu_src_b  out  2  (0=B reg, 1=const 2, 2=imm); alu_op  out  ALUOP_W; pc_src  out  1  (0=ALU result, 1=ALUOut reg).
REQ-007 Ports SHALL be: illegal_op  out  1  one-cycle pulse; halted  out  1  halt indicator; state_o  out  4  current state encoding.

Function
REQ-008 The block SHALL be a Moore FSM, states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
REQ-009 Opcode map SHALL be: 0x0-0x3 R-type ADD/SUB/AND/OR; 0x4 ADDI; 0x5 LW; 0x6 SW; 0x7 BEQ; 0x8 BNE; 0x9 JMP; 0xF HALT; all others illegal.
REQ-010 ALU codes SHALL be ADD=0, SUB=1, AND=2, OR=3; R-type EXEC_R SHALL drive alu_op = opcode.
REQ-011 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0; ir_write and pc_write SHALL be 1 only while mem_ready=1; FETCH SHALL hold until mem_ready=1, then go to DECODE.
REQ-012 DECODE: alu_src_a=0, alu_src_b=2, alu_op=ADD (branch target into ALUOut); next state by opcode per REQ-009.
REQ-013 EXEC_R: alu_src_a=2, alu_src_b=0; EXEC_I: alu_src_a=2, alu_src_b=2, alu_op=ADD; both SHALL go to ALU_WB.
REQ-014 ALU_WB: reg_write=1, mem_to_reg=0; SHALL return to FETCH.
REQ-015 MEM_ADDR: alu_src_a=2, alu_src_b=2, alu_op=ADD; SHALL go to MEM_RD (LW) or MEM_WR (SW).
REQ-016 MEM_RD: mem_read=1, i_or_d=1; MEM_WR: mem_write=1, i_or_d=1; each SHALL hold until mem_ready=1, then go to MEM_WB (LW) or FETCH (SW).
REQ-017 MEM_WB: reg_write=1, mem_to_reg=1; SHALL return to FETCH.
REQ-018 BRANCH: alu_src_a=2, alu_src_b=0, alu_op=SUB, pc_src=1; pc_write SHALL equal zero for BEQ and !zero for BNE; SHALL return to FETCH.
REQ-019 JUMP: alu_src_a=3, alu_src_b=2, alu_op=OR, pc_src=0, pc_write=1; SHALL return to FETCH.
REQ-020 Illegal opcode in DECODE SHALL pulse illegal_op for exactly one cycle and return to FETCH with no register, memory or PC write.
REQ-021 Cycle counts with mem_ready tied high SHALL be: R-type/ADDI 4, LW 5, SW 4, BEQ/BNE/JMP 3; each low mem_ready cycle adds one.
REQ-022 Outputs not listed for a state SHALL be 0; mem_read and mem_write SHALL never be high together.

Reset
REQ-023 reset low SHALL asynchronously force state FETCH, illegal_op=0 and halted=0.
REQ-024 While reset is low, pc_write, ir_write, reg_write, mem_read and mem_write SHALL be forced 0; reset mid-instruction SHALL abandon it.
REQ-025 After reset is released, the first rising clk edge SHALL begin a fetch.

Configuration
REQ-026 With CTRL_HALT_EN defined, opcode 0xF SHALL enter HALT; HALT keeps halted=1 and every strobe 0 until reset.
REQ-027 Without CTRL_HALT_EN, opcode 0xF SHALL be treated as illegal per REQ-020, and halted SHALL be tied to 0.

Structure
REQ-028 A shared package SHALL hold the state enum, opcode constants, ALU op codes and ALUSrcA/ALUSrcB/PCSrc select constants, for use by the datapath too.
REQ-029 One sub-module, ctrl_decode, SHALL map state and opcode to the control output vector combinationally; the top SHALL hold only the state register and next-state logic.

Verification
REQ-030 ADD (0x0), mem_ready=1 -> FETCH, DECODE, EXEC_R (alu_op=0), ALU_WB (reg_write=1) -> FETCH, 4 cycles.
REQ-031 LW (0x5), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_read=1 and i_or_d=1 throughout, then MEM_WB with mem_to_reg=1.
REQ-032 BEQ with zero=1 -> pc_write=1, pc_src=1 in BRANCH; BNE with zero=1 -> pc_write=0.
REQ-033 Opcode 0xB -> illegal_op high exactly one cycle, no strobes, next state FETCH.
REQ-034 reset low during MEM_WR -> strobes 0 immediately, state_o=FETCH, fetch resumes after release.
REQ-035 Opcode 0xF -> halted=1 and strobes 0 indefinitely with CTRL_HALT_EN; illegal_op pulse without it.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller and its datapath.
// Defining CTRL_HALT_EN makes opcode 0xF a legal HALT; otherwise it decodes as illegal.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_ALU_WB   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10,
    ST_HALT     = 4'd11
  } state_e;

  localparam logic [3:0] OPC_ADD  = 4'h0;
  localparam logic [3:0] OPC_SUB  = 4'h1;
  localparam logic [3:0] OPC_AND  = 4'h2;
  localparam logic [3:0] OPC_OR   = 4'h3;
  localparam logic [3:0] OPC_ADDI = 4'h4;
  localparam logic [3:0] OPC_LW   = 4'h5;
  localparam logic [3:0] OPC_SW   = 4'h6;
  localparam logic [3:0] OPC_BEQ  = 4'h7;
  localparam logic [3:0] OPC_BNE  = 4'h8;
  localparam logic [3:0] OPC_JMP  = 4'h9;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_TWO  = 2'd1;
  localparam logic [1:0] SRCA_REG  = 2'd2;
  localparam logic [1:0] SRCA_IMM  = 2'd3;
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_TWO  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic       PCSRC_ALU    = 1'b0;
  localparam logic       PCSRC_ALUOUT = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       pc_src;
    logic       illegal_op;
    logic       halted;
  } ctrl_t;

  // State entered after DECODE; ST_FETCH marks an illegal opcode.
  function automatic state_e decode_target(input logic [3:0] opc);
    state_e tgt;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: tgt = ST_EXEC_R;
      OPC_ADDI:                          tgt = ST_EXEC_I;
      OPC_LW, OPC_SW:                    tgt = ST_MEM_ADDR;
      OPC_BEQ, OPC_BNE:                  tgt = ST_BRANCH;
      OPC_JMP:                           tgt = ST_JUMP;
`ifdef CTRL_HALT_EN
      OPC_HALT:                          tgt = ST_HALT;
`endif
      default:                           tgt = ST_FETCH;
    endcase
    return tgt;
  endfunction

  function automatic logic opc_is_legal(input logic [3:0] opc);
    return decode_target(opc) != ST_FETCH;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR opcode and status in, control strobes and selects out.
interface multicycle_control_if #(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4
);
  logic [OPC_W-1:0]   opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               mem_to_reg;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               pc_src;
  logic               illegal_op;
  logic               halted;
  logic [3:0]         state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, halted, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal_op, halted, state_o
  );
endinterface

// File: rtl/multicycle_control_ctrl_decode.sv
// Output decoder: maps the current state (plus IR opcode, Zero, mem_ready) to the control vector.
// HALT only drives halted when CTRL_HALT_EN is defined.
module ctrl_decode
  import multicycle_control_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  input  logic       rst_n_i,
  output ctrl_t      ctrl_o
);

  ctrl_t raw;

  always_comb begin
    raw = '0;
    case (state_i)
      ST_FETCH: begin
        raw.mem_read  = 1'b1;
        raw.alu_src_a = SRCA_PC;
        raw.alu_src_b = SRCB_TWO;
        raw.alu_op    = ALU_ADD;
        raw.pc_src    = PCSRC_ALU;
        raw.ir_write  = mem_ready_i;
        raw.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        raw.alu_src_a  = SRCA_PC;
        raw.alu_src_b  = SRCB_IMM;
        raw.alu_op     = ALU_ADD;
        raw.illegal_op = !opc_is_legal(opcode_i);
      end
      ST_EXEC_R: begin
        raw.alu_src_a = SRCA_REG;
        raw.alu_src_b = SRCB_REG;
        raw.alu_op    = opcode_i;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        raw.alu_src_a = SRCA_REG;
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = ALU_ADD;
      end
      ST_ALU_WB: raw.reg_write = 1'b1;
      ST_MEM_RD: begin
        raw.mem_read = 1'b1;
        raw.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        raw.reg_write  = 1'b1;
        raw.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        raw.mem_write = 1'b1;
        raw.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        raw.alu_src_a = SRCA_REG;
        raw.alu_src_b = SRCB_REG;
        raw.alu_op    = ALU_SUB;
        raw.pc_src    = PCSRC_ALUOUT;
        raw.pc_write  = (opcode_i == OPC_BEQ) ? zero_i : ((opcode_i == OPC_BNE) && !zero_i);
      end
      ST_JUMP: begin
        raw.alu_src_a = SRCA_IMM;
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = ALU_OR;
        raw.pc_src    = PCSRC_ALU;
        raw.pc_write  = 1'b1;
      end
      ST_HALT: begin
`ifdef CTRL_HALT_EN
        raw.halted = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Reset parks the FSM in FETCH, whose mem_read must not reach memory until release.
  always_comb begin
    ctrl_o = raw;
    if (!rst_n_i) begin
      ctrl_o.pc_write  = 1'b0;
      ctrl_o.ir_write  = 1'b0;
      ctrl_o.reg_write = 1'b0;
      ctrl_o.mem_read  = 1'b0;
      ctrl_o.mem_write = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: state register and next-state logic; outputs come from ctrl_decode.
// Defining CTRL_HALT_EN enables the HALT state for opcode 0xF.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_e           state_q;
  state_e           state_d;
  logic [OPC_W-1:0] opc_raw;
  logic [3:0]       opc;
  ctrl_t            ctrl;

  assign opc_raw = bus.opcode;
  assign opc     = 4'(opc_raw);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (bus.mem_ready) state_d = ST_DECODE;
      ST_DECODE:   state_d = decode_target(opc);
      ST_EXEC_R,
      ST_EXEC_I:   state_d = ST_ALU_WB;
      ST_ALU_WB:   state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (opc == OPC_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (bus.mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   if (bus.mem_ready) state_d = ST_FETCH;
      ST_BRANCH,
      ST_JUMP:     state_d = ST_FETCH;
`ifdef CTRL_HALT_EN
      ST_HALT:     state_d = ST_HALT;
`else
      ST_HALT:     state_d = ST_FETCH;
`endif
      default:     state_d = ST_FETCH;
    endcase
  end

  ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opc),
    .zero_i      (bus.zero),
    .mem_ready_i (bus.mem_ready),
    .rst_n_i     (reset),
    .ctrl_o      (ctrl)
  );

  assign bus.pc_write   = ctrl.pc_write;
  assign bus.i_or_d     = ctrl.i_or_d;
  assign bus.mem_read   = ctrl.mem_read;
  assign bus.mem_write  = ctrl.mem_write;
  assign bus.ir_write   = ctrl.ir_write;
  assign bus.reg_write  = ctrl.reg_write;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.alu_op     = ALUOP_W'(ctrl.alu_op);
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.halted     = ctrl.halted;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model queues per-cycle expectations.
// Honors CTRL_HALT_EN the same way the design does.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

`ifdef CTRL_HALT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  typedef enum int {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT, S_RESET
  } step_e;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic       pc_src;
    logic       illegal;
    logic       halted;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPC_W(4), .ALUOP_W(4)) bus ();

  multicycle_control #(.OPC_W(4), .ALUOP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t  exp_q[$];
  string name_q[$];
  step_e plan_q[$];
  logic  rdy_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cycle_cnt = 0;
  int    n_instr = 0;
  int    zero_mode = -1;
  int    reset_countdown = -1;
  bit    inject_en = 1'b0;
  bit    aborted = 1'b0;

  function automatic logic legal_op(input logic [3:0] opc);
    return (opc <= 4'd9) || (HALT_ON && (opc == 4'hF));
  endfunction

  // Instruction-level sequence of FSM steps; memory steps repeat while mem_ready is low.
  function automatic void build_plan(input logic [3:0] opc);
    plan_q = {S_FETCH, S_DECODE};
    if (opc <= 4'd3) begin
      plan_q.push_back(S_EXEC_R); plan_q.push_back(S_ALU_WB);
    end else if (opc == 4'd4) begin
      plan_q.push_back(S_EXEC_I); plan_q.push_back(S_ALU_WB);
    end else if (opc == 4'd5) begin
      plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_RD); plan_q.push_back(S_MEM_WB);
    end else if (opc == 4'd6) begin
      plan_q.push_back(S_MEM_ADDR); plan_q.push_back(S_MEM_WR);
    end else if (opc == 4'd7 || opc == 4'd8) begin
      plan_q.push_back(S_BRANCH);
    end else if (opc == 4'd9) begin
      plan_q.push_back(S_JUMP);
    end else if (opc == 4'hF && HALT_ON) begin
      plan_q.push_back(S_HALT);
    end
  endfunction

  function automatic obs_t expect_of(input step_e s, input logic [3:0] opc,
                                     input logic rdy, input logic z);
    obs_t e;
    e = '0;
    case (s)
      S_RESET:    begin e.state = ST_FETCH; e.src_b = 2'd1; end
      S_FETCH:    begin e.state = ST_FETCH; e.mem_read = 1'b1; e.src_b = 2'd1;
                        e.ir_write = rdy; e.pc_write = rdy; end
      S_DECODE:   begin e.state = ST_DECODE; e.src_b = 2'd2; e.illegal = !legal_op(opc); end
      S_EXEC_R:   begin e.state = ST_EXEC_R; e.src_a = 2'd2; e.alu_op = opc; end
      S_EXEC_I:   begin e.state = ST_EXEC_I; e.src_a = 2'd2; e.src_b = 2'd2; end
      S_ALU_WB:   begin e.state = ST_ALU_WB; e.reg_write = 1'b1; end
      S_MEM_ADDR: begin e.state = ST_MEM_ADDR; e.src_a = 2'd2; e.src_b = 2'd2; end
      S_MEM_RD:   begin e.state = ST_MEM_RD; e.mem_read = 1'b1; e.i_or_d = 1'b1; end
      S_MEM_WB:   begin e.state = ST_MEM_WB; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin e.state = ST_MEM_WR; e.mem_write = 1'b1; e.i_or_d = 1'b1; end
      S_BRANCH:   begin e.state = ST_BRANCH; e.src_a = 2'd2; e.alu_op = 4'd1; e.pc_src = 1'b1;
                        e.pc_write = (opc == 4'd7) ? z : !z; end
      S_JUMP:     begin e.state = ST_JUMP; e.src_a = 2'd3; e.src_b = 2'd2; e.alu_op = 4'd3;
                        e.pc_write = 1'b1; end
      S_HALT:     begin e.state = ST_HALT; e.halted = 1'b1; end
      default:    ;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.state      = bus.state_o;
    a.pc_write   = bus.pc_write;
    a.i_or_d     = bus.i_or_d;
    a.mem_read   = bus.mem_read;
    a.mem_write  = bus.mem_write;
    a.ir_write   = bus.ir_write;
    a.reg_write  = bus.reg_write;
    a.mem_to_reg = bus.mem_to_reg;
    a.src_a      = bus.alu_src_a;
    a.src_b      = bus.alu_src_b;
    a.alu_op     = bus.alu_op;
    a.pc_src     = bus.pc_src;
    a.illegal    = bus.illegal_op;
    a.halted     = bus.halted;
    return a;
  endfunction

  task automatic push_exp(input obs_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      reset         = 1'b0;
      bus.opcode    = 4'($urandom_range(0, 15));
      bus.zero      = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      cycle_cnt++;
      push_exp(expect_of(S_RESET, 4'h0, 1'b0, 1'b0), "RESET");
    end
  endtask

  // One clock of stimulus; may instead assert reset mid-cycle, abandoning the instruction.
  task automatic apply_cycle(input step_e s, input logic [3:0] opc, input logic rdy);
    logic z;
    bit   inject;
    @(posedge clk); #1;
    z = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
    inject = inject_en && ($urandom_range(0, 99) == 0);
    if (reset_countdown > 0) begin
      reset_countdown--;
      if (reset_countdown == 0) begin
        inject = 1'b1;
        reset_countdown = -1;
      end
    end
    bus.opcode    = (s == S_FETCH) ? 4'($urandom_range(0, 15)) : opc;
    bus.zero      = z;
    bus.mem_ready = rdy;
    cycle_cnt++;
    if (inject) begin
      reset   = 1'b0;
      aborted = 1'b1;
      push_exp(expect_of(S_RESET, opc, rdy, z), $sformatf("RESET_IN_%s", s.name()));
    end else begin
      reset = 1'b1;
      push_exp(expect_of(s, opc, rdy, z), s.name());
    end
  endtask

  task automatic mem_step(input step_e s, input logic [3:0] opc);
    logic rdy;
    int   waits;
    waits = 0;
    do begin
      if (rdy_q.size() > 0) rdy = rdy_q.pop_front();
      else if (waits >= 3)  rdy = 1'b1;
      else                  rdy = ($urandom_range(0, 3) != 0);
      apply_cycle(s, opc, rdy);
      waits++;
    end while (!rdy && !aborted);
  endtask

  task automatic run_instr(input logic [3:0] opc);
    int c0;
    build_plan(opc);
    aborted = 1'b0;
    c0 = cycle_cnt;
    foreach (plan_q[i]) begin
      if (!aborted) begin
        case (plan_q[i])
          S_FETCH, S_MEM_RD, S_MEM_WR: mem_step(plan_q[i], opc);
          S_HALT: begin
            for (int k = 0; k < 8; k++)
              if (!aborted) apply_cycle(S_HALT, opc, 1'($urandom_range(0, 1)));
            if (!aborted) do_reset(1);
          end
          default: apply_cycle(plan_q[i], opc, 1'($urandom_range(0, 1)));
        endcase
      end
    end
    n_instr++;
    $display("instr %0d opc=%h cycles=%0d%s", n_instr, opc, cycle_cnt - c0,
             aborted ? " (reset)" : "");
  endtask

  // Monitor: every queued expectation is checked against the DUT half a cycle later.
  obs_t  mon_exp;
  obs_t  mon_act;
  string mon_name;
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        mon_act  = sample();
        n_cmp++;
        if (mon_act !== mon_exp) begin
          n_err++;
          $display("FAIL %s @%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                   mon_name, $time, mon_act.state, mon_act, mon_exp.state, mon_exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.opcode    = 4'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset(3);

    rdy_q = {1'b1};
    run_instr(4'h0);                          // ADD, 4 cycles
    rdy_q = {1'b1, 1'b0, 1'b0, 1'b1};
    run_instr(4'h5);                          // LW, MEM_RD held 3 cycles
    zero_mode = 1;
    run_instr(4'h7);                          // BEQ taken
    run_instr(4'h8);                          // BNE not taken
    zero_mode = 0;
    run_instr(4'h7);
    run_instr(4'h8);
    zero_mode = -1;
    run_instr(4'hB);                          // illegal
    rdy_q = {1'b1, 1'b0};
    reset_countdown = 5;
    run_instr(4'h6);                          // SW, reset lands in second MEM_WR cycle
    rdy_q = {1'b1};
    run_instr(4'h1);                          // fetch resumes after release
    run_instr(4'hF);
    run_instr(4'h9);
    run_instr(4'h4);

    inject_en = 1'b1;
    for (int n = 0; n < 1500; n++) run_instr(4'($urandom_range(0, 15)));
    inject_en = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
